// File: rtl/regfile_sb_pkg.sv
// Shared constants for the register file / scoreboard and anything that
// talks to it (datapath, hazard unit).
//   XLEN_DEFAULT  : default data word width
//   NREGS_DEFAULT : default architectural register count
//   aw_of()       : address width needed for a given register count
package regfile_sb_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // ceil(log2(n)); NREGS is a power of two, so this is exact.
    function automatic int aw_of(input int n);
        int w;
        for (w = 0; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One read port of the register file.
//   regs_flat     : all register contents, register i at [i*XLEN +: XLEN]
//   busy          : scoreboard busy bits (bit 0 is always 0)
//   ra            : read address
//   we/wa/wd      : writeback happening this cycle (bypass source)
//   wr_keeps_busy : writeback target is also being reserved this cycle
//   rd            : read data (combinational)
//   rbusy         : hazard flag for the addressed register (combinational)
module regfile_sb_rdport
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = aw_of(NREGS)
) (
    input  logic [NREGS*XLEN-1:0] regs_flat,
    input  logic [NREGS-1:0]      busy,
    input  logic [AW-1:0]         ra,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  wr_keeps_busy,
    output logic [XLEN-1:0]       rd,
    output logic                  rbusy
);

    logic ra_zero;
    logic bypass;

    assign ra_zero = (ra == '0);
    assign bypass  = we && (wa == ra) && !ra_zero;

    always_comb begin
        if (ra_zero) begin
            rd = '0;
        end else if (bypass) begin
            rd = wd;
        end else begin
            rd = regs_flat[ra*XLEN +: XLEN];
        end
    end

    // The value arriving this cycle resolves the hazard, unless the same
    // register is being re-reserved by a newer producer.
    assign rbusy = busy[ra] && !(bypass && !wr_keeps_busy);

endmodule

// File: rtl/regfile_sb.sv
// Register file with integrated scoreboard.
//   clk, reset    : clock, synchronous active-high reset
//   ra / rd       : NRD packed read addresses / read data (bypassed)
//   rbusy         : per-port busy flag of the addressed register
//   we/wa/wd      : writeback; also clears the target's busy bit
//   rsv_en/rsv_a  : reserve a destination register (set busy)
//   rsv_conflict  : registered pulse, reserve hit an already-busy register
//   busy_cnt      : registered number of busy registers
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    localparam int AW   = aw_of(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_a,
    output logic                rsv_conflict,
    output logic [AW:0]         busy_cnt
);

    // Register 0 has no storage; it is hard-wired to zero.
    logic [XLEN-1:0]       regs_q [NREGS-1:1];
    logic [NREGS-1:0]      busy_q, busy_d;
    logic [AW:0]           busy_cnt_q, busy_cnt_d;
    logic                  rsv_conflict_q, rsv_conflict_d;
    logic [NREGS*XLEN-1:0] regs_flat;
    logic                  wr_keeps_busy;

    assign wr_keeps_busy = we && rsv_en && (rsv_a == wa) && (wa != '0);

    // Writeback clears first, reserve sets last: the newer producer wins.
    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[wa] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_a] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 1; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    assign rsv_conflict_d = rsv_en && (rsv_a != '0) && busy_q[rsv_a]
                            && !(we && (wa == rsv_a));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q         <= '0;
            busy_cnt_q     <= '0;
            rsv_conflict_q <= 1'b0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (we && (wa == AW'(i))) begin
                    regs_q[i] <= wd;
                end
            end
            busy_q         <= busy_d;
            busy_cnt_q     <= busy_cnt_d;
            rsv_conflict_q <= rsv_conflict_d;
        end
    end

    assign rsv_conflict = rsv_conflict_q;
    assign busy_cnt     = busy_cnt_q;

    assign regs_flat[0 +: XLEN] = '0;
    for (genvar g = 1; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*XLEN +: XLEN] = regs_q[g];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rdport
        regfile_sb_rdport #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rdport (
            .regs_flat     (regs_flat),
            .busy          (busy_q),
            .ra            (ra[k*AW +: AW]),
            .we            (we),
            .wa            (wa),
            .wd            (wd),
            .wr_keeps_busy (wr_keeps_busy),
            .rd            (rd[k*XLEN +: XLEN]),
            .rbusy         (rbusy[k])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int AW    = 5;

    logic                clk;
    logic                reset;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                rsv_en;
    logic [AW-1:0]       rsv_a;
    logic                rsv_conflict;
    logic [AW:0]         busy_cnt;

    int nerr = 0;
    int nchk = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk          (clk),
        .reset        (reset),
        .ra           (ra),
        .rd           (rd),
        .rbusy        (rbusy),
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .rsv_en       (rsv_en),
        .rsv_a        (rsv_a),
        .rsv_conflict (rsv_conflict),
        .busy_cnt     (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    bit              m_conf;
    bit              model_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 0;
            end
            m_conf      = 0;
            model_valid = 1;
        end else if (model_valid) begin
            m_conf = rsv_en && rsv_a != 0 && m_busy[rsv_a] && !(we && wa == rsv_a);
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 0;
            end
            if (rsv_en && rsv_a != 0) m_busy[rsv_a] = 1;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            int cnt;
            for (int k = 0; k < NRD; k++) begin
                logic [AW-1:0]   a;
                logic [XLEN-1:0] exp_rd;
                bit              exp_b;
                a = ra[k*AW +: AW];
                if (a == 0)                exp_rd = '0;
                else if (we && wa == a)    exp_rd = wd;
                else                       exp_rd = m_regs[a];
                exp_b = m_busy[a] && !(we && wa == a && !(rsv_en && rsv_a == a));
                check("model_rd", rd[k*XLEN +: XLEN], exp_rd);
                check("model_rbusy", {63'd0, rbusy[k]}, {63'd0, exp_b});
            end
            cnt = 0;
            for (int i = 0; i < NREGS; i++) cnt += int'(m_busy[i]);
            check("model_busy_cnt", {58'd0, busy_cnt}, 64'(cnt));
            check("model_rsv_conflict", {63'd0, rsv_conflict}, {63'd0, m_conf});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra_all(input int a);
        for (int k = 0; k < NRD; k++) ra[k*AW +: AW] = AW'(a);
    endtask

    task automatic check_all_empty(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            set_ra_all(i);
            #1;
            check({tag, "_rd"}, (rd == '0) ? 64'd0 : 64'd1, 64'd0);
            check({tag, "_rbusy"}, {60'd0, rbusy}, 64'd0);
        end
        check({tag, "_busy_cnt"}, {58'd0, busy_cnt}, 64'd0);
        check({tag, "_rsv_conflict"}, {63'd0, rsv_conflict}, 64'd0);
    endtask

    initial begin
        reset = 1; we = 0; wa = '0; wd = '0; rsv_en = 0; rsv_a = '0; ra = '0;
        tick();
        tick();
        reset = 0;
        check_all_empty("reset");

        // Write-through bypass and r0 immunity.
        set_ra_all(0);
        ra[0 +: AW] = 5;
        we = 1; wa = 5; wd = 64'hDEADBEEF;
        #1;
        check("bypass_rd0", rd[0 +: XLEN], 64'hDEADBEEF);
        tick();
        we = 0;
        ra[AW +: AW] = 5;
        #1;
        check("after_write_rd1", rd[XLEN +: XLEN], 64'hDEADBEEF);
        we = 1; wa = 0; wd = 64'h1234; set_ra_all(0);
        #1;
        check("r0_bypass_blocked", rd[0 +: XLEN], 64'd0);
        tick();
        we = 0;
        #1;
        check("r0_reads_zero", rd[0 +: XLEN], 64'd0);

        // Reserve r3, r7, then write back r3.
        rsv_en = 1; rsv_a = 3; tick();
        rsv_a = 7; tick();
        rsv_en = 0; set_ra_all(3);
        #1;
        check("cnt_two", {58'd0, busy_cnt}, 64'd2);
        check("rbusy_r3", {63'd0, rbusy[0]}, 64'd1);
        we = 1; wa = 3; wd = 64'hA5A5;
        #1;
        check("rbusy_r3_bypassed", {63'd0, rbusy[0]}, 64'd0);
        tick();
        we = 0;
        #1;
        check("cnt_one", {58'd0, busy_cnt}, 64'd1);
        check("rbusy_r3_cleared", {63'd0, rbusy[0]}, 64'd0);

        // New producer wins over simultaneous writeback; then a conflict.
        rsv_en = 1; rsv_a = 9; tick();
        we = 1; wa = 9; wd = 64'h55; set_ra_all(9);
        #1;
        check("rbusy_r9_kept", {63'd0, rbusy[0]}, 64'd1);
        tick();
        we = 0; rsv_en = 0;
        #1;
        check("r9_data", rd[0 +: XLEN], 64'h55);
        check("r9_busy", {63'd0, rbusy[0]}, 64'd1);
        check("cnt_pair", {58'd0, busy_cnt}, 64'd2);
        check("no_conflict_pair", {63'd0, rsv_conflict}, 64'd0);
        rsv_en = 1; rsv_a = 9; tick();
        rsv_en = 0;
        #1;
        check("conflict_pulse", {63'd0, rsv_conflict}, 64'd1);
        check("cnt_after_conflict", {58'd0, busy_cnt}, 64'd2);
        tick();
        check("conflict_drop", {63'd0, rsv_conflict}, 64'd0);

        // Fill the scoreboard, then reset with requests pending.
        for (int i = 1; i < NREGS; i++) begin
            rsv_en = 1; rsv_a = AW'(i); tick();
        end
        rsv_en = 0;
        #1;
        check("cnt_full", {58'd0, busy_cnt}, 64'd31);
        reset = 1; rsv_en = 1; rsv_a = 4; we = 1; wa = 6; wd = 64'hFFFF;
        tick();
        reset = 0; rsv_en = 0; we = 0;
        check_all_empty("midreset");

        // Random traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            int sel;
            sel   = $urandom_range(0, 1);
            we    = ($urandom_range(0, 2) != 0);
            wa    = sel ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
            wd    = {$urandom, $urandom};
            rsv_en = ($urandom_range(0, 1) != 0);
            rsv_a = sel ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
            if ($urandom_range(0, 3) == 0) rsv_a = wa;
            for (int k = 0; k < NRD; k++) begin
                case ($urandom_range(0, 3))
                    0:       ra[k*AW +: AW] = wa;
                    1:       ra[k*AW +: AW] = rsv_a;
                    default: ra[k*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
                endcase
            end
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 0; we = 0; rsv_en = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data word width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, at least 2.
REQ-003 Parameter NRD, default 2, number of independent read ports.
REQ-004 Derived constant AW = log2(NREGS), address width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous reset, active-high.
REQ-007 ra  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-008 rd  out  NRD*XLEN  packed read data, combinational, port k at [k*XLEN +: XLEN].
REQ-009 rbusy  out  NRD  per-port scoreboard busy flag for the addressed register, combinational.
REQ-010 we  in  1  write (writeback) enable.
REQ-011 wa  in  AW  write address.
REQ-012 wd  in  XLEN  write data.
REQ-013 rsv_en  in  1  reserve request: mark a destination register as pending.
REQ-014 rsv_a  in  AW  reserve address.
REQ-015 rsv_conflict  out  1  registered pulse; reserve hit an already-busy register.
REQ-016 busy_cnt  out  AW+1  registered count of busy registers.

Function
REQ-017 Register 0 SHALL always read 0, ignore writes, and never be busy or counted as busy.
REQ-018 Write: on a rising edge with we=1 and wa!=0, reg[wa] SHALL take wd.
REQ-019 Read: rd port k SHALL return reg[ra_k], except when we=1, wa=ra_k and wa!=0, where it returns wd (write-through bypass, zero latency).
REQ-020 Scoreboard: on a rising edge with rsv_en=1 and rsv_a!=0, busy[rsv_a] SHALL be set.
REQ-021 A write with we=1 SHALL clear busy[wa] on the same edge, unless REQ-022 applies.
REQ-022 Simultaneous reserve and write to the same nonzero register: data SHALL be written and busy SHALL stay or become 1 (the new producer wins).
REQ-023 rbusy_k SHALL equal busy[ra_k], forced to 0 when we=1 and wa=ra_k and the REQ-022 case does not apply (the bypass also clears the hazard).
REQ-024 rsv_conflict SHALL be 1 for exactly the cycle after an edge where rsv_en=1, rsv_a!=0, busy[rsv_a]=1, and not (we=1 and wa=rsv_a).
REQ-025 busy_cnt SHALL equal the population count of busy[] after each edge: +1 on a new set, -1 on a clear, unchanged when a set and a clear occur together or the events cancel; range 0..NREGS-1, never wraps.
REQ-026 Reads SHALL be side-effect free; any number of ports may address the same register.

Reset
REQ-027 With reset=1 at an edge, all registers, all busy bits, busy_cnt and rsv_conflict SHALL become 0; we and rsv_en in that cycle SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL discard pending reservations; the first post-reset cycle behaves as an empty scoreboard.
REQ-029 The block SHALL have no initial blocks; reset is the only initialisation.

Structure
REQ-030 A shared package SHALL hold the XLEN/NREGS defaults and the AW derivation function, for reuse by the CPU datapath and hazard unit.
REQ-031 One sub-module, regfile_sb_rdport, SHALL implement a single read port (mux, bypass, busy masking) and be instantiated NRD times in a generate loop.
REQ-032 The expected RTL size is 120-400 lines, including the sub-module.

Verification
REQ-033 Reset, then read all registers on every port -> each reads 0, rbusy=0, busy_cnt=0.
REQ-034 Write 0xDEADBEEF to r5 with ra0=5 in the same cycle -> rd0=0xDEADBEEF combinationally; after the edge, a read of r5 still returns it; a write of 0x1234 to r0 -> r0 reads 0.
REQ-035 Reserve r3 and r7 -> busy_cnt=2 and rbusy=1 on reads of r3; write r3 -> busy_cnt=1 and rbusy on r3 = 0.
REQ-036 Reserve r9 and write r9=0x55 on the same edge -> r9=0x55, busy[r9]=1, busy_cnt unchanged by the pair; reserve r9 again -> rsv_conflict pulses for one cycle.
REQ-037 Reserve r1..r31 -> busy_cnt=31; assert reset mid-sequence -> all counts, busy bits and data are 0 on the next cycle.
REQ-038 With NRD=4 and XLEN=64, run random writes, reserves and reads against a reference model -> no mismatches over 10k cycles.
